seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter that drives the input of the sequence detector. On a start request it latches a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock. It repeats the pattern a programmable number of times, with a programmable idle gap between repetitions. It flags the final bit of each repetition (the cycle the detector must fire) and pulses done at the end of the burst.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of repetition count
GAP_W, 4, width of inter-repetition gap count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  burst request, sampled only in IDLE
pattern  input  PAT_W  pattern to transmit, bit PAT_W-1 sent first
repeat_n  input  CNT_W  number of pattern repetitions (0 = none)
gap  input  GAP_W  idle cycles inserted between repetitions
abort  input  1  cancel burst in progress
dout  output  1  serial data bit
dout_valid  output  1  dout carries a pattern bit this cycle
last_bit  output  1  dout is final bit of a repetition
busy  output  1  burst in progress (SHIFT, GAP or DONE)
done  output  1  one-cycle pulse, burst completed normally

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high, ports clk and rst. All outputs are registered.
- Reset values: dout=0, dout_valid=0, last_bit=0, busy=0, done=0. The state is IDLE and all internal counters and latches are 0.
- Reset priority: rst overrides everything, including mid-burst. The next cycle is IDLE with all outputs 0 and no done pulse.
- States:
  - IDLE: outputs 0.
    - start=1 and repeat_n!=0: latch pattern, repeat_n and gap; go to SHIFT.
    - start=1 and repeat_n=0: go to DONE.
  - SHIFT: dout = latched pattern bit (MSB first), dout_valid=1. The bit counter counts 0..PAT_W-1.
    - last_bit=1 when the bit counter = PAT_W-1.
    - After that bit, decrement the remaining-repetition count.
    - If the remaining count is now 0: go to DONE.
    - Else if the latched gap = 0: restart SHIFT with no bubble.
    - Else: go to GAP.
  - GAP: dout=0, dout_valid=0 for exactly gap cycles, then SHIFT.
  - DONE: done=1 for one cycle, busy=1; then IDLE.
- Latency: start sampled high in cycle 0. First bit is valid in cycle 1. DONE occurs in cycle R*PAT_W + (R-1)*G + 1, where R = repeat_n and G = gap. For R=0, DONE occurs in cycle 1.
- busy=0 only in IDLE. A start pulse while busy (including the DONE cycle) is ignored and not queued.
- Input changes to pattern, repeat_n or gap during a burst have no effect; the latched copies are used.
- abort=1 in SHIFT, GAP or DONE: the next cycle is IDLE with all outputs 0 and no done pulse. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: abort has no effect and start is accepted.
- Counters do not wrap. repeat_n up to 2^CNT_W-1 and gap up to 2^GAP_W-1 are honoured exactly.

Test Plan:
- Single burst: pattern=4'b1011, repeat_n=1, gap=0, start in cycle 0 -> cycles 1-4: dout=1,0,1,1 with dout_valid=1; last_bit only in cycle 4; done in cycle 5; busy in cycles 1-5; IDLE in cycle 6.
- Back-to-back repeat: same pattern, repeat_n=2, gap=0 -> dout_valid is high in cycles 1-8, stream 10111011, last_bit in cycles 4 and 8, done in cycle 9.
- Gap insertion: repeat_n=2, gap=3 -> bits in cycles 1-4; cycles 5-7 have dout_valid=0 and dout=0; bits in cycles 8-11; done in cycle 12.
- Zero repeat: repeat_n=0, start in cycle 0 -> no dout_valid ever; busy=1 and done=1 in cycle 1; idle in cycle 2.
- Ignore and abort: start again in cycle 2 with pattern=4'b0000 -> the stream is unchanged. Then abort=1 in cycle 3 -> cycle 4 has all outputs 0 and no done pulse; a new start in cycle 4 is accepted.
- Reset mid-burst: rst=1 in cycle 6 of a repeat_n=3 burst -> cycle 7 has all outputs 0 and busy=0; no done pulse afterwards.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// with an optional idle gap, and pulses done when the burst completes.
module seq_pattern_gen #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy,
   output logic             done
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

   state_t           state, state_n;
   logic [PAT_W-1:0] pat_q, pat_n;
   logic [CNT_W-1:0] rep_q, rep_n;
   logic [GAP_W-1:0] gap_q, gap_n;
   logic [GAP_W-1:0] gcnt_q, gcnt_n;
   logic [BW-1:0]    bit_q, bit_n;
   logic [BW-1:0]    idx;
   logic             dout_n, valid_n, last_n, busy_n, done_n;

   // Next-state logic; outputs are derived from the next state so they can be
   // registered and still line up with the state they describe.
   always_comb begin
      state_n = state;
      pat_n   = pat_q;
      rep_n   = rep_q;
      gap_n   = gap_q;
      gcnt_n  = gcnt_q;
      bit_n   = bit_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (repeat_n != '0) begin
                  pat_n   = pattern;
                  rep_n   = repeat_n;
                  gap_n   = gap;
                  bit_n   = '0;
                  state_n = S_SHIFT;
               end else begin
                  state_n = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            if (bit_q == LAST_IDX) begin
               rep_n = rep_q - CNT_W'(1);
               bit_n = '0;
               if (rep_q == CNT_W'(1)) begin
                  state_n = S_DONE;
               end else if (gap_q == '0) begin
                  state_n = S_SHIFT;
               end else begin
                  gcnt_n  = gap_q - GAP_W'(1);
                  state_n = S_GAP;
               end
            end else begin
               bit_n = bit_q + BW'(1);
            end
         end
         S_GAP: begin
            if (gcnt_q == '0) begin
               state_n = S_SHIFT;
            end else begin
               gcnt_n = gcnt_q - GAP_W'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) begin
         state_n = S_IDLE;
         bit_n   = '0;
         gcnt_n  = '0;
      end

      idx     = LAST_IDX - bit_n;
      valid_n = (state_n == S_SHIFT);
      dout_n  = valid_n & pat_n[idx];
      last_n  = valid_n & (bit_n == LAST_IDX);
      busy_n  = (state_n != S_IDLE);
      done_n  = (state_n == S_DONE);
   end

   // State, latched burst parameters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pat_q      <= '0;
         rep_q      <= '0;
         gap_q      <= '0;
         gcnt_q     <= '0;
         bit_q      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         last_bit   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         pat_q      <= pat_n;
         rep_q      <= rep_n;
         gap_q      <= gap_n;
         gcnt_q     <= gcnt_n;
         bit_q      <= bit_n;
         dout       <= dout_n;
         dout_valid <= valid_n;
         last_bit   <= last_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: a vector table for the simple bursts plus
// hand-written sequences for gaps, abort, reset and the long-count boundaries.
module tb_seq_pattern_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] pattern;
   logic [7:0] repeat_n;
   logic [3:0] gap;
   logic       abort;
   logic       dout, dout_valid, last_bit, busy, done;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic       start;
      logic [3:0] pattern;
      logic [7:0] repeat_n;
      logic [3:0] gap;
      logic       abort;
      logic       rst;
      logic [4:0] expect_out;
   } vec_t;

   vec_t vecs[$];

   seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pattern    (pattern),
      .repeat_n   (repeat_n),
      .gap        (gap),
      .abort      (abort),
      .dout       (dout),
      .dout_valid (dout_valid),
      .last_bit   (last_bit),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then advance to 1 time unit past the next edge.
   task automatic applyStimulus(input logic s, input logic [3:0] p, input logic [7:0] r,
                                input logic [3:0] g, input logic a, input logic rs);
      start    = s;
      pattern  = p;
      repeat_n = r;
      gap      = g;
      abort    = a;
      rst      = rs;
      @(posedge clk);
      #1;
   endtask

   // Compare {dout, dout_valid, last_bit, busy, done} with the expected value.
   task automatic checkOutput(input string name, input logic [4:0] exp_out);
      logic [4:0] act;
      act = {dout, dout_valid, last_bit, busy, done};
      tests_run++;
      if (act !== exp_out) begin
         tests_failed++;
         $display("[TB] FAIL %s: got {dout,valid,last,busy,done}=%b, expected %b", name, act, exp_out);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0] stream;
      int         valid_cnt;
      int         done_cycle;
      bit         bad;

      // single burst 1011, R=1, G=0
      vecs.push_back('{1'b1, 4'b1011, 8'd1, 4'd0, 1'b0, 1'b0, 5'b11010});
      vecs.push_back('{1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 5'b01010});
      vecs.push_back('{1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 5'b11010});
      vecs.push_back('{1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 5'b11110});
      vecs.push_back('{1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 5'b00011});
      vecs.push_back('{1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 5'b00000});
      // back-to-back repeat, R=2, G=0: stream 10111011
      vecs.push_back('{1'b1, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b11010});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b01010});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b11010});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b11110});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b11010});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b01010});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b11010});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b11110});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b00011});
      vecs.push_back('{1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0, 5'b00000});
      // zero repeat
      vecs.push_back('{1'b1, 4'b1111, 8'd0, 4'd0, 1'b0, 1'b0, 5'b00011});
      vecs.push_back('{1'b0, 4'b1111, 8'd0, 4'd0, 1'b0, 1'b0, 5'b00000});
      // start with abort in IDLE is accepted; abort in SHIFT returns to idle
      vecs.push_back('{1'b1, 4'b0001, 8'd1, 4'd0, 1'b1, 1'b0, 5'b01010});
      vecs.push_back('{1'b0, 4'b0001, 8'd1, 4'd0, 1'b1, 1'b0, 5'b00000});
      vecs.push_back('{1'b0, 4'b0001, 8'd1, 4'd0, 1'b0, 1'b0, 5'b00000});

      applyStimulus(1'b0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b1);
      checkOutput("reset", 5'b00000);
      idle(1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].start, vecs[i].pattern, vecs[i].repeat_n, vecs[i].gap,
                       vecs[i].abort, vecs[i].rst);
         checkOutput($sformatf("vec%0d", i), vecs[i].expect_out);
      end

      // Gap insertion R=2, G=3; inputs scrambled during the burst must not matter
      stream = 4'b1011;
      applyStimulus(1'b1, 4'b1011, 8'd2, 4'd3, 1'b0, 1'b0);
      for (int c = 1; c <= 13; c++) begin
         logic [4:0] e;
         if (c <= 4)       e = {stream[4-c], 1'b1, (c == 4), 1'b1, 1'b0};
         else if (c <= 7)  e = 5'b00010;
         else if (c <= 11) e = {stream[11-c], 1'b1, (c == 11), 1'b1, 1'b0};
         else if (c == 12) e = 5'b00011;
         else              e = 5'b00000;
         checkOutput($sformatf("gap_c%0d", c), e);
         if (c < 13) applyStimulus(1'b0, 4'b0100, 8'd9, 4'd0, 1'b0, 1'b0);
      end

      // Ignored start while busy, then abort, then a fresh start
      applyStimulus(1'b1, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0);
      checkOutput("ign_c1", 5'b11010);
      applyStimulus(1'b0, 4'b1011, 8'd2, 4'd0, 1'b0, 1'b0);
      checkOutput("ign_c2", 5'b01010);
      applyStimulus(1'b1, 4'b0000, 8'd2, 4'd0, 1'b0, 1'b0);
      checkOutput("ign_c3", 5'b11010);
      applyStimulus(1'b0, 4'b0000, 8'd2, 4'd0, 1'b1, 1'b0);
      checkOutput("abort_c4", 5'b00000);
      applyStimulus(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 1'b0);
      checkOutput("restart_c5", 5'b01010);
      applyStimulus(1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("restart_c6", 5'b11010);
      idle(2);
      checkOutput("restart_c8", 5'b01110);
      applyStimulus(1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("restart_done", 5'b00011);
      applyStimulus(1'b1, 4'b1111, 8'd1, 4'd0, 1'b0, 1'b0);
      checkOutput("start_in_done_ignored", 5'b00000);

      // Reset mid-burst R=3
      applyStimulus(1'b1, 4'b1011, 8'd3, 4'd0, 1'b0, 1'b0);
      idle(5);
      checkOutput("rst_pre_c6", 5'b01010);
      applyStimulus(1'b0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b1);
      checkOutput("rst_c7", 5'b00000);
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         idle(1);
         if (busy || done || dout_valid) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("[TB] FAIL rst_no_done: got activity after reset, expected none");
      end

      // Long burst boundaries: G=15 (max) and R=255 (max), done cycle exact
      for (int k = 0; k < 2; k++) begin
         logic [7:0] r;
         logic [3:0] g;
         int         exp_done, exp_valid;
         r = (k == 0) ? 8'd2 : 8'd255;
         g = (k == 0) ? 4'd15 : 4'd0;
         exp_done  = (k == 0) ? 24 : 1021;
         exp_valid = (k == 0) ? 8 : 1020;
         valid_cnt  = 0;
         done_cycle = -1;
         applyStimulus(1'b1, 4'b1001, r, g, 1'b0, 1'b0);
         for (int c = 1; c <= 1100 && done_cycle < 0; c++) begin
            if (dout_valid) valid_cnt++;
            if (done) done_cycle = c;
            if (done_cycle < 0) applyStimulus(1'b0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
         end
         tests_run++;
         if (done_cycle != exp_done) begin
            tests_failed++;
            $display("[TB] FAIL long%0d_done_cycle: got %0d, expected %0d", k, done_cycle, exp_done);
         end
         tests_run++;
         if (valid_cnt != exp_valid) begin
            tests_failed++;
            $display("[TB] FAIL long%0d_valid_count: got %0d, expected %0d", k, valid_cnt, exp_valid);
         end
         idle(1);
         checkOutput($sformatf("long%0d_idle", k), 5'b00000);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
